// File: rtl/cnn_layer_accel_macc_seq.sv
// Sequencer for an external DSP MACC: gates CE, times opmode against the product pipeline.
// Optional PCIN-cascaded first term is enabled with CNN_LAYER_ACCEL_MACC_SEQ_CASCADE_EN.
module cnn_layer_accel_macc_seq #(
    parameter int unsigned C_LEN_WIDTH   = 8,
    parameter int unsigned C_OPMODE_LEAD = 2,
    parameter int unsigned C_PIPE_DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [C_LEN_WIDTH-1:0] cfg_len_i,
`ifdef CNN_LAYER_ACCEL_MACC_SEQ_CASCADE_EN
    input  logic                   cfg_cascade_i,
`endif
    input  logic                   op_valid_i,
    output logic                   op_ready_o,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic                   busy_o,
    output logic                   dsp_ce_o,
    output logic [8:0]             dsp_opmode_o,
    output logic [3:0]             dsp_alumode_o,
    output logic                   dsp_rst_o
);

    localparam logic [8:0] OpMul  = 9'b000000101;
    localparam logic [8:0] OpAcc  = 9'b000100101;
    localparam logic [8:0] OpPcin = 9'b000010101;
    localparam int unsigned DrainW = (C_PIPE_DEPTH > 2) ? $clog2(C_PIPE_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StAccum, StDrain, StHold} state_e;

    state_e                              state_q, state_d;
    logic [C_LEN_WIDTH-1:0]              cnt_q, cnt_d;
    logic [C_LEN_WIDTH-1:0]              len_q, len_d;
    logic [DrainW-1:0]                   drain_q, drain_d;
    logic [C_OPMODE_LEAD-1:0][8:0]       opsr_q, opsr_d;
`ifdef CNN_LAYER_ACCEL_MACC_SEQ_CASCADE_EN
    logic                                casc_q, casc_d;
`endif

    logic       op_ready, res_valid, ce;
    logic [8:0] op_in;
    logic [8:0] op_first;

`ifdef CNN_LAYER_ACCEL_MACC_SEQ_CASCADE_EN
    assign op_first = casc_q ? OpPcin : OpMul;
`else
    assign op_first = OpMul;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        drain_d   = drain_q;
        opsr_d    = opsr_q;
`ifdef CNN_LAYER_ACCEL_MACC_SEQ_CASCADE_EN
        casc_d    = casc_q;
`endif
        op_ready  = 1'b0;
        res_valid = 1'b0;
        ce        = 1'b0;
        // Bubbles carry the accumulate opmode; CE stops before they reach the ALU.
        op_in     = OpAcc;

        unique case (state_q)
            StIdle: begin
                if (start_i && (cfg_len_i != '0)) begin
                    state_d = StAccum;
                    len_d   = cfg_len_i;
                    cnt_d   = '0;
`ifdef CNN_LAYER_ACCEL_MACC_SEQ_CASCADE_EN
                    casc_d  = cfg_cascade_i;
`endif
                end
            end
            StAccum: begin
                op_ready = 1'b1;
                ce       = op_valid_i;
                if (op_valid_i) begin
                    op_in = (cnt_q == '0) ? op_first : OpAcc;
                    cnt_d = cnt_q + C_LEN_WIDTH'(1);
                    if (cnt_d == len_q) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end
                end
            end
            StDrain: begin
                ce = 1'b1;
                if (drain_q == DrainW'(C_PIPE_DEPTH - 2)) begin
                    state_d = StHold;
                end else begin
                    drain_d = drain_q + DrainW'(1);
                end
            end
            StHold: begin
                res_valid = 1'b1;
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (ce) begin
            opsr_d[0] = op_in;
            for (int i = 1; i < int'(C_OPMODE_LEAD); i++) begin
                opsr_d[i] = opsr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
            drain_q <= '0;
            opsr_q  <= '0;
`ifdef CNN_LAYER_ACCEL_MACC_SEQ_CASCADE_EN
            casc_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            drain_q <= drain_d;
            opsr_q  <= opsr_d;
`ifdef CNN_LAYER_ACCEL_MACC_SEQ_CASCADE_EN
            casc_q  <= casc_d;
`endif
        end
    end

    // Reset forces the handshake/CE outputs low in the same cycle it is asserted.
    assign op_ready_o    = op_ready & ~rst_i;
    assign res_valid_o   = res_valid & ~rst_i;
    assign dsp_ce_o      = ce & ~rst_i;
    assign busy_o        = (state_q != StIdle) & ~rst_i;
    assign dsp_opmode_o  = opsr_q[C_OPMODE_LEAD-1];
    assign dsp_alumode_o = 4'b0000;
    assign dsp_rst_o     = rst_i;

endmodule

// File: tb/tb_cnn_layer_accel_macc_seq.sv
// Bench for cnn_layer_accel_macc_seq: drives the sequencer against a behavioural DSP MACC and
// scoreboards the final P and the opmode applied to every product.
module tb_cnn_layer_accel_macc_seq;

    localparam int unsigned LenW  = 8;
    localparam int unsigned Lead  = 2;
    localparam int unsigned Depth = 4;
    localparam logic [31:0] Pcin  = 32'd100;
`ifdef CNN_LAYER_ACCEL_MACC_SEQ_CASCADE_EN
    localparam bit CascEn = 1'b1;
`else
    localparam bit CascEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [LenW-1:0] cfg_len = '0;
    logic            cascade = 1'b0;
    logic            op_valid = 1'b0;
    logic            res_ready = 1'b1;
    logic [7:0]      op_a = '0;
    logic [7:0]      op_b = '0;
    logic            op_ready, res_valid, busy, dsp_ce, dsp_rst;
    logic [8:0]      dsp_opmode;
    logic [3:0]      dsp_alumode;

    always #5 clk = ~clk;

    cnn_layer_accel_macc_seq #(
        .C_LEN_WIDTH   (LenW),
        .C_OPMODE_LEAD (Lead),
        .C_PIPE_DEPTH  (Depth)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .cfg_len_i     (cfg_len),
`ifdef CNN_LAYER_ACCEL_MACC_SEQ_CASCADE_EN
        .cfg_cascade_i (cascade),
`endif
        .op_valid_i    (op_valid),
        .op_ready_o    (op_ready),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .busy_o        (busy),
        .dsp_ce_o      (dsp_ce),
        .dsp_opmode_o  (dsp_opmode),
        .dsp_alumode_o (dsp_alumode),
        .dsp_rst_o     (dsp_rst)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_acc = 0;
    int ready_cnt = 0;
    int term = 0;
    bit casc_run = 1'b0;
    logic [31:0] exp_sum = '0;
    logic [31:0] resq[$];
    logic [8:0]  opq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural MACC: A1/B1, A2/B2, M, OPMODE and P registers all on the shared CE.
    logic [7:0]  ma1, mb1, ma2, mb2;
    logic        v1, v2, vm;
    logic [15:0] m_q;
    logic [8:0]  opreg;
    logic [31:0] p_q;

    function automatic logic [31:0] alu(input logic [8:0] opm, input logic [15:0] m,
                                        input logic [31:0] p, input logic [31:0] pc);
        logic [31:0] z, xy;
        xy = (opm[3:0] == 4'b0101) ? {16'b0, m} : 32'b0;
        case (opm[6:4])
            3'b010:  z = p;
            3'b001:  z = pc;
            default: z = 32'b0;
        endcase
        return z + xy;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dsp_rst) begin
            ma1 <= '0; mb1 <= '0; ma2 <= '0; mb2 <= '0;
            v1 <= 1'b0; v2 <= 1'b0; vm <= 1'b0;
            m_q <= '0; opreg <= '0; p_q <= '0;
        end else if (dsp_ce) begin
            ma1   <= op_a;
            mb1   <= op_b;
            v1    <= op_valid && op_ready;
            ma2   <= ma1;
            mb2   <= mb1;
            v2    <= v1;
            m_q   <= {8'b0, ma2} * {8'b0, mb2};
            vm    <= v2;
            opreg <= dsp_opmode;
            p_q   <= alu(opreg, m_q, p_q, Pcin);
        end
    end

    always @(negedge clk) begin
        if (op_ready) ready_cnt++;
        if (dsp_ce && vm) begin
            if (opq.size() == 0) check_eq("extra_opmode", {23'b0, opreg}, 32'h1ff);
            else check_eq("opmode", {23'b0, opreg}, {23'b0, opq.pop_front()});
        end
        if (res_valid && res_ready) begin
            if (resq.size() == 0) check_eq("unexpected_res", {31'b0, res_valid}, 32'd0);
            else check_eq("result_p", p_q, resq.pop_front());
        end
    end

    task automatic begin_run(input int len, input bit casc);
        @(posedge clk); #1;
        start    = 1'b1;
        cfg_len  = LenW'(len);
        cascade  = casc;
        casc_run = casc && CascEn;
        exp_sum  = casc_run ? Pcin : 32'd0;
        term     = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        op_valid = 1'b1;
        op_a = a;
        op_b = b;
        @(negedge clk);
        while (!op_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("feed_ready", {31'b0, op_ready}, 32'd1);
        opq.push_back(term == 0 ? (casc_run ? 9'h015 : 9'h005) : 9'h025);
        exp_sum += {24'b0, a} * {24'b0, b};
        term++;
        @(posedge clk); #1;
        op_valid = 1'b0;
        last_acc = cyc;
    endtask

    task automatic stall(input int n);
        op_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("stall_ce", {31'b0, dsp_ce}, 32'd0);
            check_eq("stall_ready", {31'b0, op_ready}, 32'd1);
            @(posedge clk); #1;
        end
    endtask

    // Ends at posedge+1 phase; hold = cycles res_ready stays low once res_valid rises.
    task automatic collect(input int hold);
        int n = 0;
        resq.push_back(exp_sum);
        res_ready = (hold == 0);
        @(negedge clk);
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("res_valid_seen", {31'b0, res_valid}, 32'd1);
        check_eq("latency", cyc - last_acc, Depth - 1);
        for (int i = 0; i < hold; i++) begin
            check_eq("hold_valid", {31'b0, res_valid}, 32'd1);
            check_eq("hold_ce", {31'b0, dsp_ce}, 32'd0);
            check_eq("hold_p", p_q, exp_sum);
            @(posedge clk); #1;
            if (i == hold - 1) res_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("idle_after", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit seen;
        int len;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_dsp_rst", {31'b0, dsp_rst}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_ready", {31'b0, op_ready}, 32'd0);
        check_eq("rst_valid", {31'b0, res_valid}, 32'd0);
        check_eq("rst_ce", {31'b0, dsp_ce}, 32'd0);
        check_eq("rst_opmode", {23'b0, dsp_opmode}, 32'd0);
        check_eq("rst_alumode", {28'b0, dsp_alumode}, 32'd0);
        check_eq("rst_dsp_rst_low", {31'b0, dsp_rst}, 32'd0);

        // Three terms back to back: 2*3 + 4*5 + 6*7 = 68.
        begin_run(3, 1'b0);
        ready_cnt = 0;
        feed(8'd2, 8'd3);
        feed(8'd4, 8'd5);
        feed(8'd6, 8'd7);
        check_eq("ready_cycles", ready_cnt, 3);
        collect(0);

        // Two-cycle stall between terms 2 and 3.
        begin_run(4, 1'b0);
        feed(8'd1, 8'd1);
        feed(8'd1, 8'd1);
        stall(2);
        feed(8'd1, 8'd1);
        feed(8'd1, 8'd1);
        collect(0);

        // Single term with back-pressure on the result.
        begin_run(1, 1'b0);
        feed(8'd5, 8'd9);
        collect(5);

        // Zero-length start is ignored.
        start = 1'b1;
        cfg_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("len0_busy", {31'b0, busy}, 32'd0);
        check_eq("len0_ce", {31'b0, dsp_ce}, 32'd0);
        @(posedge clk); #1;

        // Start and a new length while accumulating are ignored.
        begin_run(3, 1'b0);
        feed(8'd10, 8'd11);
        start = 1'b1;
        cfg_len = 8'd7;
        stall(1);
        start = 1'b0;
        feed(8'd12, 8'd13);
        feed(8'd14, 8'd15);
        collect(0);

        // Reset after two of five terms aborts the run.
        begin_run(5, 1'b0);
        feed(8'd3, 8'd4);
        feed(8'd5, 8'd6);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_dsp_rst", {31'b0, dsp_rst}, 32'd1);
        check_eq("abort_valid", {31'b0, res_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        opq.delete();
        @(negedge clk);
        check_eq("abort_idle", {31'b0, busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check_eq("abort_no_valid", {31'b0, seen}, 32'd0);
        begin_run(2, 1'b0);
        feed(8'd7, 8'd8);
        feed(8'd9, 8'd10);
        collect(0);

        // Cascaded first term: 110 with the feature built in, 10 without.
        begin_run(2, 1'b1);
        feed(8'd3, 8'd3);
        feed(8'd1, 8'd1);
        check_eq("casc_expect", exp_sum, CascEn ? 32'd110 : 32'd10);
        collect(0);

        // Random lengths, operands and stalls.
        for (int r = 0; r < 4; r++) begin
            len = int'($urandom_range(2, 9));
            begin_run(len, 1'b0);
            for (int t = 0; t < len; t++) begin
                if ($urandom_range(0, 3) == 0) stall(int'($urandom_range(1, 2)));
                feed(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
            collect(int'($urandom_range(0, 2)));
        end

        check_eq("opq_drained", opq.size(), 0);
        check_eq("resq_drained", resq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
